// File: rtl/golden_tx_pkg.sv
// Shared types and constants for the golden-nonce return path: TX FSM encoding,
// nonce byte count, and 8N1 framing constants.
package golden_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int   NONCE_W        = 32;
  localparam int   NONCE_BYTES    = 4;
  localparam int   UART_DATA_BITS = 8;
  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;

  // Byte 0 is the most significant byte; the host expects MSB-first words.
  function automatic logic [7:0] nonce_byte(input logic [NONCE_W-1:0] word,
                                            input logic [1:0]         idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/golden_nonce_tx_fifo.sv
// Small nonce queue with wrap-bit pointers; flush discards everything queued
// and any push arriving in the same cycle.
module nonce_fifo #(
  parameter int FIFO_LOG2 = 2,
  parameter int WIDTH     = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [WIDTH-1:0]     push_data,
  input  logic                 pop,
  input  logic                 flush,
  output logic [WIDTH-1:0]     pop_data,
  output logic                 full,
  output logic                 empty,
  output logic [FIFO_LOG2:0]   level
);

  localparam int                 DEPTH   = 1 << FIFO_LOG2;
  localparam logic [FIFO_LOG2:0] DEPTH_L = (FIFO_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [FIFO_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_LOG2:0] rd_ptr_q, rd_ptr_d;
  logic               push_ok;
  logic               pop_ok;

  assign level    = wr_ptr_q - rd_ptr_q;
  assign full     = (level == DEPTH_L);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign pop_data = mem_q[rd_ptr_q[FIFO_LOG2-1:0]];

  // When full, a same-cycle pop frees the slot the push lands in.
  always_comb begin
    push_ok  = push & ~flush & (~full | pop);
    pop_ok   = pop & ~empty;
    wr_ptr_d = wr_ptr_q + {{FIFO_LOG2{1'b0}}, push_ok};
    rd_ptr_d = flush ? wr_ptr_q : rd_ptr_q + {{FIFO_LOG2{1'b0}}, pop_ok};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[FIFO_LOG2-1:0]] <= push_data;
  end

endmodule

// File: rtl/golden_nonce_tx.sv
// Golden-nonce return path: captures miner reports into a queue and sends each
// nonce MSB-first as four 8N1 UART bytes to the host.
//
//   state | meaning
//   IDLE  | line high, pop next queued nonce when available
//   START | start bit (low) for one bit time
//   DATA  | 8 data bits of the current byte, LSB first
//   STOP  | stop bit (high); next byte or back to IDLE
module golden_nonce_tx
  import golden_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_LOG2    = 2
) (
  input  logic                 hash_clk,
  input  logic                 reset_n,
  input  logic                 is_golden,
  input  logic [NONCE_W-1:0]   nonce_in,
  input  logic                 flush,
  output logic                 uart_txd,
  output logic                 busy,
  output logic                 overflow,
  output logic [FIFO_LOG2:0]   fifo_level
);

  localparam logic [15:0] BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);
  localparam logic [1:0]  LAST_BYTE   = 2'(NONCE_BYTES - 1);
  localparam logic [2:0]  LAST_BIT    = 3'(UART_DATA_BITS - 1);

  logic [1:0]         rst_sync_q, rst_sync_d;
  logic               rst_n_int;

  tx_state_e          state_q, state_d;
  logic [15:0]        baud_q, baud_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [1:0]         byte_idx_q, byte_idx_d;
  logic [NONCE_W-1:0] word_q, word_d;
  logic               txd_q, txd_d;
  logic               cap_q, cap_d;
  logic               ovf_q, ovf_d;

  logic               fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_drop;
  logic [NONCE_W-1:0] fifo_rdata;
  logic [7:0]         cur_byte_d;
  logic               baud_done;

  // Assert asynchronously, release two edges later so flops leave reset together.
  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign rst_n_int  = rst_sync_q[1];

  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= '0;
    else          rst_sync_q <= rst_sync_d;
  end

  // The miner presents nonce_out one cycle after its strobe.
  always_comb begin
    cap_d     = flush ? 1'b0 : is_golden;
    fifo_push = cap_q & ~flush;
    fifo_drop = fifo_push & fifo_full & ~fifo_pop;
    ovf_d     = flush ? 1'b0 : (ovf_q | fifo_drop);
  end

  nonce_fifo #(
    .FIFO_LOG2 (FIFO_LOG2),
    .WIDTH     (NONCE_W)
  ) u_fifo (
    .clk       (hash_clk),
    .rst_n     (rst_n_int),
    .push      (fifo_push),
    .push_data (nonce_in),
    .pop       (fifo_pop),
    .flush     (flush),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_ff @(posedge hash_clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q    <= ST_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      txd_q      <= UART_STOP_BIT;
      cap_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      txd_q      <= txd_d;
      cap_q      <= cap_d;
      ovf_q      <= ovf_d;
    end
  end

  assign baud_done = (baud_q == 16'd0);

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    fifo_pop   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          word_d     = fifo_rdata;
          byte_idx_d = '0;
          bit_idx_d  = '0;
          baud_d     = BAUD_RELOAD;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        if (baud_done) begin
          bit_idx_d = '0;
          baud_d    = BAUD_RELOAD;
          state_d   = ST_DATA;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (baud_done) begin
          baud_d = BAUD_RELOAD;
          if (bit_idx_q == LAST_BIT) state_d = ST_STOP;
          else                       bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      ST_STOP: begin
        if (baud_done) begin
          if (byte_idx_q != LAST_BYTE) begin
            byte_idx_d = byte_idx_q + 2'd1;
            baud_d     = BAUD_RELOAD;
            state_d    = ST_START;
          end else begin
            bit_idx_d  = '0;
            byte_idx_d = '0;
            baud_d     = '0;
            state_d    = ST_IDLE;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line level is decoded from the next state so uart_txd is a plain flop.
  always_comb begin
    cur_byte_d = nonce_byte(word_d, byte_idx_d);
    txd_d      = UART_STOP_BIT;
    case (state_d)
      ST_START: txd_d = UART_START_BIT;
      ST_DATA:  txd_d = cur_byte_d[bit_idx_d];
      default:  txd_d = UART_STOP_BIT;
    endcase
  end

  assign uart_txd = txd_q;
  assign overflow = ovf_q;
  assign busy     = (state_q != ST_IDLE) | (fifo_level != '0);

endmodule

// File: tb/tb_golden_nonce_tx.sv
// Directed bench for golden_nonce_tx: decodes the UART line and checks values,
// frame timing, queue level, overflow, flush and async reset behaviour.
module tb_golden_nonce_tx;

  localparam int CPB = 4;
  localparam int FL2 = 2;

  logic          hash_clk;
  logic          reset_n;
  logic          is_golden;
  logic [31:0]   nonce_in;
  logic          flush;
  logic          uart_txd;
  logic          busy;
  logic          overflow;
  logic [FL2:0]  fifo_level;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int peak     = 0;

  int          t, t2, tx, s0, s1;
  logic [31:0] w, w2;
  logic [31:0] ws [6];
  logic [31:0] vals [8];
  logic [FL2:0] lvl_pre, lvl_snap;
  logic        ovf_snap;
  logic        low_seen;

  golden_nonce_tx #(.CLKS_PER_BIT(CPB), .FIFO_LOG2(FL2)) dut (
    .hash_clk   (hash_clk),
    .reset_n    (reset_n),
    .is_golden  (is_golden),
    .nonce_in   (nonce_in),
    .flush      (flush),
    .uart_txd   (uart_txd),
    .busy       (busy),
    .overflow   (overflow),
    .fifo_level (fifo_level)
  );

  initial hash_clk = 1'b0;
  always #5 hash_clk = ~hash_clk;
  always @(posedge hash_clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, observed running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge hash_clk);
    if (int'(fifo_level) > peak) peak = int'(fifo_level);
  endtask

  task automatic report(input logic [31:0] v, output int tr);
    @(negedge hash_clk);
    is_golden = 1'b1;
    nonce_in  = ~v;
    tr        = cyc;
    @(negedge hash_clk);
    is_golden = 1'b0;
    nonce_in  = v;
  endtask

  // is_golden high for n consecutive cycles; each nonce follows its strobe.
  task automatic burst(input int n, output int tr);
    @(negedge hash_clk);
    is_golden = 1'b1;
    nonce_in  = 32'hBAD0BAD0;
    tr        = cyc;
    for (int i = 1; i < n; i++) begin
      @(negedge hash_clk);
      nonce_in = vals[i-1];
    end
    @(negedge hash_clk);
    is_golden = 1'b0;
    nonce_in  = vals[n-1];
  endtask

  task automatic recv_byte(input string tag, output logic [7:0] b, output int s);
    bit found;
    found = 1'b0;
    b     = 8'h00;
    s     = 0;
    for (int n = 0; n < 2000 && !found; n++) begin
      tick();
      if (uart_txd === 1'b0) begin
        found = 1'b1;
        s     = cyc;
      end
    end
    check({tag, "_start_seen"}, 32'(found), 32'd1);
    if (found) begin
      tick();
      tick();
      check({tag, "_start_bit"}, 32'(uart_txd), 32'd0);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) tick();
        b[i] = uart_txd;
      end
      repeat (CPB) tick();
      check({tag, "_stop_bit"}, 32'(uart_txd), 32'd1);
    end
  endtask

  task automatic recv_word(input string tag, output logic [31:0] wo, output int so);
    logic [7:0] b;
    int s;
    wo = '0;
    so = 0;
    for (int k = 0; k < 4; k++) begin
      recv_byte(tag, b, s);
      if (k == 0) so = s;
      else check({tag, "_byte_gap"}, 32'(s), 32'(so + 10 * CPB * k));
      wo = {wo[23:0], b};
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    is_golden = 1'b0;
    nonce_in  = '0;
    flush     = 1'b0;
    repeat (3) @(negedge hash_clk);
    check("rst_txd", 32'(uart_txd), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    reset_n = 1'b1;
    repeat (4) @(negedge hash_clk);
    check("idle_txd", 32'(uart_txd), 32'd1);

    // Single report
    report(32'h1D2C3B4A, t);
    recv_word("single", w, s0);
    check("single_latency", 32'(s0), 32'(t + 3));
    check("single_word", w, 32'h1D2C3B4A);
    tick();
    check("single_busy_last_stop", 32'(busy), 32'd1);
    tick();
    check("single_busy_after", 32'(busy), 32'd0);
    check("single_txd_after", 32'(uart_txd), 32'd1);

    // Back-to-back reports two cycles apart
    peak = 0;
    fork
      begin
        report(32'h00000001, t);
        report(32'hFFFFFFFE, t2);
      end
      begin
        recv_word("b2b_a", w, s0);
        recv_word("b2b_b", w2, s1);
      end
    join
    check("b2b_latency", 32'(s0), 32'(t + 3));
    check("b2b_word_a", w, 32'h00000001);
    check("b2b_word_b", w2, 32'hFFFFFFFE);
    check("b2b_gap", 32'(s1), 32'(s0 + 40 * CPB + 1));
    check("b2b_peak", 32'(peak), 32'd1);

    // Six consecutive reports: one in flight, four queued, one dropped
    for (int i = 0; i < 6; i++) vals[i] = 32'h11111111 * (i + 1);
    peak = 0;
    fork
      burst(6, t);
      for (int k = 0; k < 5; k++) recv_word("ovf", ws[k], s0);
    join
    check("ovf_sticky", 32'(overflow), 32'd1);
    check("ovf_peak", 32'(peak), 32'd4);
    check("ovf_w0", ws[0], 32'h11111111);
    check("ovf_w1", ws[1], 32'h22222222);
    check("ovf_w2", ws[2], 32'h33333333);
    check("ovf_w3", ws[3], 32'h44444444);
    check("ovf_w4", ws[4], 32'h55555555);
    check("ovf_level_end", 32'(fifo_level), 32'd0);

    // Flush during byte 2 of the frame in flight, three queued behind it
    vals[0] = 32'hA1A2A3A4; vals[1] = 32'hB1B2B3B4;
    vals[2] = 32'hC1C2C3C4; vals[3] = 32'hD1D2D3D4;
    fork
      burst(4, t);
      recv_word("flush", w, s0);
      begin
        repeat (89) @(negedge hash_clk);
        flush = 1'b1;
        @(negedge hash_clk);
        flush = 1'b0;
      end
    join
    check("flush_word", w, 32'hA1A2A3A4);
    check("flush_level", 32'(fifo_level), 32'd0);
    check("flush_ovf_cleared", 32'(overflow), 32'd0);
    low_seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (uart_txd !== 1'b1) low_seen = 1'b1;
    end
    check("flush_no_more_frames", 32'(low_seen), 32'd0);
    check("flush_busy", 32'(busy), 32'd0);

    // Full queue with push and pop in the same IDLE cycle
    for (int i = 0; i < 5; i++) vals[i] = 32'h0F0F0F00 + 32'(i);
    fork
      burst(5, t);
      for (int k = 0; k < 6; k++) recv_word("fullpp", ws[k], s0);
      begin
        repeat (162) @(negedge hash_clk);
        report(32'hC6C6C6C6, tx);
        lvl_pre = fifo_level;
        @(negedge hash_clk);
        lvl_snap = fifo_level;
        ovf_snap = overflow;
      end
    join
    check("fullpp_level_before", 32'(lvl_pre), 32'd4);
    check("fullpp_level_after", 32'(lvl_snap), 32'd4);
    check("fullpp_no_ovf", 32'(ovf_snap), 32'd0);
    for (int k = 0; k < 5; k++) check("fullpp_word", ws[k], 32'h0F0F0F00 + 32'(k));
    check("fullpp_word_last", ws[5], 32'hC6C6C6C6);
    check("fullpp_ovf_end", 32'(overflow), 32'd0);

    // Async reset while a data bit (low) is on the line
    report(32'h12345678, t);
    report(32'hDEADBEEF, t2);
    repeat (5) @(negedge hash_clk);
    check("arst_pre_txd", 32'(uart_txd), 32'd0);
    check("arst_pre_level", 32'(fifo_level), 32'd1);
    reset_n = 1'b0;
    #1;
    check("arst_txd", 32'(uart_txd), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_level", 32'(fifo_level), 32'd0);
    repeat (3) @(negedge hash_clk);
    reset_n = 1'b1;
    low_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (uart_txd !== 1'b1) low_seen = 1'b1;
    end
    check("arst_no_stale", 32'(low_seen), 32'd0);
    report(32'h00000000, t);
    recv_word("zero", w, s0);
    check("zero_latency", 32'(s0), 32'(t + 3));
    check("zero_word", w, 32'h00000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
